// File: rtl/video_shifter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_shifter_pkg : shared constants, mode/timing types, load mux   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package video_shifter_pkg;

  localparam int PIPE_DEPTH = 3;
  localparam int CHAR_W     = 8;
  localparam int ROM_ROWS   = 16;
  localparam int ROW_W      = $clog2(ROM_ROWS);
  localparam int MA_W       = 14;
  localparam int RA_W       = 5;
  localparam int CROM_AW    = CHAR_W + ROW_W;

  typedef enum logic {
    TEXT   = 1'b0,
    BITMAP = 1'b1
  } mode_e;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

  // Blanking (DE low) overrides everything; rows past the ROM height are blank in text mode.
  function automatic logic [CHAR_W-1:0] stage2_load(
    input mode_e             mode,
    input logic              blank_row,
    input logic              de,
    input logic [CHAR_W-1:0] vbyte,
    input logic [CHAR_W-1:0] rom
  );
    logic [CHAR_W-1:0] v;
    if (!de)                  v = '0;
    else if (mode == BITMAP)  v = vbyte;
    else if (blank_row)       v = '0;
    else                      v = rom;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_shifter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_shifter_if : video RAM and character ROM read bus             |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface video_shifter_if;
  import video_shifter_pkg::*;

  logic [MA_W-1:0]    VRAM_ADDR;
  logic [CHAR_W-1:0]  VRAM_DATA;
  logic [CROM_AW-1:0] CROM_ADDR;
  logic [CHAR_W-1:0]  CROM_DATA;

  modport master (
    output VRAM_ADDR,
    output CROM_ADDR,
    input  VRAM_DATA,
    input  CROM_DATA
  );

  modport slave (
    input  VRAM_ADDR,
    input  CROM_ADDR,
    output VRAM_DATA,
    output CROM_DATA
  );

endinterface
`default_nettype wire

// File: rtl/video_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_delay_line : CHAR_CE-clocked delay line with one mid tap      |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int TAP   = 0
) (
  input  wire logic             CLOCK,
  input  wire logic             nRESET,
  input  wire logic             CHAR_CE,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_tap,
  output logic      [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge CLOCK) begin
        if (!nRESET)      r_taps[0] <= '0;
        else if (CHAR_CE) r_taps[0] <= i_d;
      end
    end else begin : g_chain
      always_ff @(posedge CLOCK) begin
        if (!nRESET)      r_taps <= '0;
        else if (CHAR_CE) r_taps <= {r_taps[DEPTH-2:0], i_d};
      end
    end
  endgenerate

  assign o_tap = r_taps[TAP];
  assign o_q   = r_taps[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_shifter : 3-stage CRTC fetch pipeline and serial pixel shifter|
// | option macro CURSOR_INVERT_EN : invert the cursor cell. rev 1.0     |
// +--------------------------------------------------------------------+
module video_shifter
  import video_shifter_pkg::*;
(
  input  wire logic            CLOCK,
  input  wire logic            nRESET,
  input  wire logic            CHAR_CE,
  input  wire logic            PIX_CE,
  input  wire logic [MA_W-1:0] MA,
  input  wire logic [RA_W-1:0] RA,
  input  wire logic            DE,
  input  wire logic            CURSOR,
  input  wire logic            HSYNC_IN,
  input  wire logic            VSYNC_IN,
  input  wire logic            GFX,
  video_shifter_if.master      mem,
  output logic                 PIXEL,
  output logic                 DE_OUT,
  output logic                 HSYNC_OUT,
  output logic                 VSYNC_OUT
);

  logic [MA_W-1:0]    r_vram_addr;
  logic [RA_W-1:0]    r_ra_s0;
  mode_e              r_mode_s0;
  logic [CROM_AW-1:0] r_crom_addr;
  logic [CHAR_W-1:0]  r_vbyte_s1;
  mode_e              r_mode_s1;
  logic               r_blank_row_s1;
  logic [CHAR_W-1:0]  r_shift;

  logic [TIMING_W-1:0] w_timing_in;
  logic [TIMING_W-1:0] w_tap;
  logic [TIMING_W-1:0] w_q;
  timing_t             w_t_s1;
  timing_t             w_t_out;
  logic [1:0]          w_unused_s1_sync;
  logic [CHAR_W-1:0]   w_base_load;
  logic [CHAR_W-1:0]   w_load;

  assign w_timing_in = timing_t'{de: DE, hsync: HSYNC_IN, vsync: VSYNC_IN};

  video_delay_line #(
    .WIDTH (TIMING_W),
    .DEPTH (PIPE_DEPTH),
    .TAP   (1)
  ) u_timing_dly (
    .CLOCK   (CLOCK),
    .nRESET  (nRESET),
    .CHAR_CE (CHAR_CE),
    .i_d     (w_timing_in),
    .o_tap   (w_tap),
    .o_q     (w_q)
  );

  assign w_t_s1           = timing_t'(w_tap);
  assign w_t_out          = timing_t'(w_q);
  assign w_unused_s1_sync = {w_t_s1.hsync, w_t_s1.vsync};

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_vram_addr    <= '0;
      r_ra_s0        <= '0;
      r_mode_s0      <= TEXT;
      r_crom_addr    <= '0;
      r_vbyte_s1     <= '0;
      r_mode_s1      <= TEXT;
      r_blank_row_s1 <= 1'b0;
    end else if (CHAR_CE) begin
      r_vram_addr    <= MA;
      r_ra_s0        <= RA;
      r_mode_s0      <= mode_e'(GFX);
      r_crom_addr    <= {mem.VRAM_DATA, r_ra_s0[ROW_W-1:0]};
      r_vbyte_s1     <= mem.VRAM_DATA;
      r_mode_s1      <= r_mode_s0;
      r_blank_row_s1 <= |r_ra_s0[RA_W-1:ROW_W];
    end
  end

  assign w_base_load = stage2_load(r_mode_s1, r_blank_row_s1, w_t_s1.de,
                                   r_vbyte_s1, mem.CROM_DATA);

`ifdef CURSOR_INVERT_EN
  logic r_cursor_s0;
  logic r_cursor_s1;

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_cursor_s0 <= 1'b0;
      r_cursor_s1 <= 1'b0;
    end else if (CHAR_CE) begin
      r_cursor_s0 <= CURSOR;
      r_cursor_s1 <= r_cursor_s0;
    end
  end

  assign w_load = w_base_load ^ {CHAR_W{r_cursor_s1 & w_t_s1.de}};
`else
  logic w_unused_cursor;
  assign w_unused_cursor = CURSOR;
  assign w_load          = w_base_load;
`endif

  // A coincident CHAR_CE reloads; the previous character's last bit was already shown.
  always_ff @(posedge CLOCK) begin
    if (!nRESET)      r_shift <= '0;
    else if (CHAR_CE) r_shift <= w_load;
    else if (PIX_CE)  r_shift <= {r_shift[CHAR_W-2:0], 1'b0};
  end

  assign mem.VRAM_ADDR = r_vram_addr;
  assign mem.CROM_ADDR = r_crom_addr;

  assign PIXEL     = r_shift[CHAR_W-1] & w_t_out.de;
  assign DE_OUT    = w_t_out.de;
  assign HSYNC_OUT = w_t_out.hsync;
  assign VSYNC_OUT = w_t_out.vsync;

endmodule
`default_nettype wire
